mux2_1: RTL and testbench
=========================

# mux2_1

Two-input selector primitive for the LED369 datapath, and the leaf cell used three times by `mux4_1` to build a 4:1 selector. It provides a combinational output `out = sel ? i1 : i0` with zero clock latency, so it works unclocked in `mux4_1`. It also provides an optional registered copy of that output and a saturating count of select transitions, for use in clocked pipelines and for debug.

## Interface
Parameters:
- `WIDTH`, default 1: data width of `i0`, `i1`, `out` and `out_q`.
- `CNT_W`, default 8: width of the select-transition counter.

Ports:
- `clk`, input, 1: single clock. All sequential state updates on its rising edge.
- `reset`, input, 1: reset, asynchronous, active-high. Asserting it clears all registers immediately. Deasserting it takes effect at the next `clk` rising edge.
- `i0`, input, WIDTH: data, selected when `sel`=0.
- `i1`, input, WIDTH: data, selected when `sel`=1.
- `sel`, input, 1: select.
- `en`, input, 1: load enable for `out_q`. Tie to 1 for a plain pipeline register.
- `out`, output, WIDTH: combinational mux result.
- `out_q`, output, WIDTH: registered mux result.
- `sel_q`, output, 1: `sel` value sampled at the last rising edge.
- `sel_cnt`, output, CNT_W: saturating count of `sel` changes between consecutive rising edges.

## Operation
- `out` is combinational: `out = sel ? i1 : i0`, bitwise across WIDTH.
  - It has no dependence on `clk`, `reset` or `en`.
  - It must be correct when `clk` and `reset` are left unconnected (the `mux4_1` usage).
- `out_q`:
  - On a rising edge with `reset`=0 and `en`=1, it loads the current value of `out`.
  - With `en`=0, it holds.
- `sel_q` loads `sel` on every rising edge with `reset`=0, independent of `en`.
- `sel_cnt`:
  - Increments by 1 on a rising edge when `sel` ≠ `sel_q`.
  - Saturates at 2^CNT_W−1 and never wraps.
  - It is independent of `en`.
- Reset values: `out_q` = 0, `sel_q` = 0, `sel_cnt` = 0. `out` is unaffected by reset.
- Simultaneous events:
  - `reset` has priority over `en` and over counting.
  - Reset asserted mid-operation clears the registers at once. No partial update occurs on that edge.
- Inputs are treated as two-state. Behaviour with X/Z on `sel` is not specified.

## Timing
- `out`: 0 cycles latency, pure combinational path from `i0`/`i1`/`sel`.
- `out_q`: 1 cycle latency. It reflects `out` as sampled at edge N and is visible after edge N.
- `sel_q`: 1 cycle latency.
- `sel_cnt`: updates at the same edge that samples the changed `sel`.
- The first edge after reset release compares `sel` against `sel_q`=0. A `sel`=1 held through reset release therefore counts as one transition.
- The combinational path and the registered path have no ordering dependency.

## Test plan
- Exhaustive combinational sweep: step `{sel,i0,i1}` through all 8 values at 10 ns per step with WIDTH=1. Require `out`=`i0` when `sel`=0 and `out`=`i1` when `sel`=1; for example `{1,0,1}` gives 1 and `{0,0,1}` gives 0. Also instantiate `mux4_1` and sweep `{sel1,sel0,i00,i01,i10,i11}` from 0 to 63. Require `out` = selected input, with `sel1` picking the upper pair.
- Registered path: set WIDTH=8, `i0`=0x3C, `i1`=0xA5, `en`=1, and toggle `sel` each cycle. Require `out_q` to alternate 0x3C/0xA5, trailing `sel` by one edge.
- Enable hold: with `out_q`=0xA5, drive `en`=0 and switch to `sel`=0 for 3 edges. Require `out_q` to stay 0xA5 while `out`=0x3C immediately.
- Counter saturation: with CNT_W=3, toggle `sel` 10 times. Require `sel_cnt` to reach 7 and hold at 7.
- Asynchronous reset mid-operation: assert `reset` between edges while `out_q`=0xA5 and `sel_cnt`=5. Require `out_q`, `sel_q` and `sel_cnt` to go to 0 before the next edge, with `out` unchanged. After release, require normal loading from the first rising edge.

Source files
------------

// File: rtl/mux2_1.sv
// Two-input selector leaf: combinational out = sel ? i1 : i0, with an optional
// enabled output register and a saturating count of select transitions.
module mux2_1 #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic             sel,
  input  logic             en,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             sel_q,
  output logic [CNT_W-1:0] sel_cnt
);

  // Pure per-bit select; nothing clocked may feed this path, since mux4_1
  // leaves clk and reset unconnected.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign out[gi] = sel ? i1[gi] : i0[gi];
    end
  endgenerate

  logic [WIDTH-1:0] out_q_reg;
  logic             sel_q_reg;
  logic [CNT_W-1:0] sel_cnt_reg;
  logic [CNT_W-1:0] sel_cnt_next;

  // A change of sel against last edge's sample is one transition; saturate at all-ones.
  always_comb begin
    sel_cnt_next = sel_cnt_reg;
    if ((sel != sel_q_reg) && (sel_cnt_reg != {CNT_W{1'b1}}))
      sel_cnt_next = sel_cnt_reg + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q_reg   <= '0;
      sel_q_reg   <= 1'b0;
      sel_cnt_reg <= '0;
    end else begin
      if (en)
        out_q_reg <= out;
      sel_q_reg   <= sel;
      sel_cnt_reg <= sel_cnt_next;
    end
  end

  assign out_q   = out_q_reg;
  assign sel_q   = sel_q_reg;
  assign sel_cnt = sel_cnt_reg;

endmodule

// File: tb/tb_mux2_1.sv
// Directed bench for mux2_1: combinational sweeps (2:1 leaf and a 4:1 built from
// three leaves), registered path, enable hold, saturation and asynchronous reset.
module tb_mux2_1;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] i0, i1;
  logic       sel, en;
  logic [7:0] out, out_q;
  logic       sel_q;
  logic [2:0] sel_cnt;

  always #5 clk = ~clk;

  mux2_1 #(.WIDTH(8), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .i0(i0), .i1(i1), .sel(sel), .en(en),
    .out(out), .out_q(out_q), .sel_q(sel_q), .sel_cnt(sel_cnt)
  );

  // 4:1 selector assembled from three unclocked leaves; sel1 picks the upper pair.
  logic       s1, s0, a00, a01, a10, a11;
  logic       lo_out, hi_out, m4_out;
  logic       lo_oq, hi_oq, m4_oq, lo_sq, hi_sq, m4_sq;
  logic [7:0] lo_cnt, hi_cnt, m4_cnt;

  mux2_1 #(.WIDTH(1)) u_lo (
    .clk(1'b0), .reset(1'b0), .i0(a00), .i1(a01), .sel(s0), .en(1'b0),
    .out(lo_out), .out_q(lo_oq), .sel_q(lo_sq), .sel_cnt(lo_cnt)
  );
  mux2_1 #(.WIDTH(1)) u_hi (
    .clk(1'b0), .reset(1'b0), .i0(a10), .i1(a11), .sel(s0), .en(1'b0),
    .out(hi_out), .out_q(hi_oq), .sel_q(hi_sq), .sel_cnt(hi_cnt)
  );
  mux2_1 #(.WIDTH(1)) u_top (
    .clk(1'b0), .reset(1'b0), .i0(lo_out), .i1(hi_out), .sel(s1), .en(1'b0),
    .out(m4_out), .out_q(m4_oq), .sel_q(m4_sq), .sel_cnt(m4_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected counter after each of eleven back-to-back toggles, CNT_W=3.
  logic [2:0] sat_tab [0:10] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7};

  initial begin
    logic [5:0] v;
    reset = 1'b1; en = 1'b0; sel = 1'b0; i0 = 8'h3C; i1 = 8'hA5;
    s1 = 1'b0; s0 = 1'b0; a00 = 1'b0; a01 = 1'b0; a10 = 1'b0; a11 = 1'b0;
    #2;
    check("rst_out_q", {24'd0, out_q}, 32'h0);
    check("rst_sel_q", {31'd0, sel_q}, 32'h0);
    check("rst_cnt",   {29'd0, sel_cnt}, 32'h0);
    check("rst_out",   {24'd0, out}, 32'h3C);

    // 2:1 leaf sweep over {sel,i0,i1}
    for (int k = 0; k < 8; k++) begin
      v = 6'(k);
      {s0, a00, a01} = v[2:0];
      #10;
      check($sformatf("leaf_%0d", k), {31'd0, lo_out}, {31'd0, (v[2] ? v[0] : v[1])});
    end

    // 4:1 sweep over {sel1,sel0,i00,i01,i10,i11}
    for (int k = 0; k < 64; k++) begin
      v = 6'(k);
      {s1, s0, a00, a01, a10, a11} = v;
      #1;
      check($sformatf("m4_%0d", k), {31'd0, m4_out}, {31'd0, v[3 - {v[5], v[4]}]});
    end

    // Release reset between edges with sel=0; first edge loads 0x3C, no count.
    @(posedge clk); #1;
    reset = 1'b0; en = 1'b1;
    tick();
    check("first_out_q", {24'd0, out_q}, 32'h3C);
    check("first_cnt",   {29'd0, sel_cnt}, 32'h0);

    // Toggle every cycle: out_q trails sel by one edge, counter saturates at 7.
    for (int k = 0; k < 11; k++) begin
      sel = ~sel;
      #1;
      check($sformatf("tog_out_%0d", k), {24'd0, out}, (k % 2 == 0) ? 32'hA5 : 32'h3C);
      check($sformatf("tog_oq_pre_%0d", k), {24'd0, out_q}, (k % 2 == 0) ? 32'h3C : 32'hA5);
      tick();
      check($sformatf("tog_oq_%0d", k), {24'd0, out_q}, (k % 2 == 0) ? 32'hA5 : 32'h3C);
      check($sformatf("tog_selq_%0d", k), {31'd0, sel_q}, (k % 2 == 0) ? 32'h1 : 32'h0);
      check($sformatf("tog_cnt_%0d", k), {29'd0, sel_cnt}, {29'd0, sat_tab[k]});
    end

    // Enable hold: out follows sel at once, out_q keeps 0xA5.
    en = 1'b0; sel = 1'b0;
    #1;
    check("hold_out", {24'd0, out}, 32'h3C);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("hold_oq_%0d", k), {24'd0, out_q}, 32'hA5);
      check($sformatf("hold_cnt_%0d", k), {29'd0, sel_cnt}, 32'h7);
    end

    // Clear, then build up out_q=0xA5 and sel_cnt=5.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      sel = ~sel;
      tick();
      check($sformatf("build_cnt_%0d", k), {29'd0, sel_cnt}, 32'(k + 1));
    end
    check("build_oq", {24'd0, out_q}, 32'hA5);

    // Asynchronous reset between edges clears registers before the next edge.
    #3 reset = 1'b1;
    #1;
    check("arst_out_q", {24'd0, out_q}, 32'h0);
    check("arst_sel_q", {31'd0, sel_q}, 32'h0);
    check("arst_cnt",   {29'd0, sel_cnt}, 32'h0);
    check("arst_out",   {24'd0, out}, 32'hA5);
    #2 reset = 1'b0;
    tick();
    check("rel_out_q", {24'd0, out_q}, 32'hA5);
    check("rel_sel_q", {31'd0, sel_q}, 32'h1);
    check("rel_cnt",   {29'd0, sel_cnt}, 32'h1);
    sel = 1'b0;
    tick();
    check("rel2_out_q", {24'd0, out_q}, 32'h3C);
    check("rel2_cnt",   {29'd0, sel_cnt}, 32'h2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
